// File: rtl/mem_link_master_if.sv
// Command, UART byte and read-return signals between mem_link_master and its environment.
// master = the initiator block, slave = command source / UART side.
interface mem_link_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_end_addr;
    logic [3:0]  cmd_wstrb;
    logic [31:0] cmd_wdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        done;
    logic        err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_end_addr, cmd_wstrb, cmd_wdata,
        input  tx_done, rx_data, rx_valid,
        output cmd_ready, tx_data, tx_start, rd_data, rd_valid, rd_last, done, err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_end_addr, cmd_wstrb, cmd_wdata,
        output tx_done, rx_data, rx_valid,
        input  cmd_ready, tx_data, tx_start, rd_data, rd_valid, rd_last, done, err
    );
endinterface

// File: rtl/mem_link_master.sv
// Byte-serial BRAM access initiator: frames write / block-read commands for a UART TX,
// one byte in flight at a time, and reassembles little-endian read words from UART RX.
module mem_link_master #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic               clk,
    input logic               rst_n,
    mem_link_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, REJECT} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // tcnt is 0 in the cycle after a byte, so TIMEOUT-2 here puts err TIMEOUT cycles after it
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    state_t state, state_nxt;

    logic        is_wr;
    logic [15:0] addr_q, end_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [2:0]  idx, idx_inc;
    logic [1:0]  bcnt;
    logic [14:0] wcnt;
    logic [13:0] span;
    logic [23:0] shreg;
    logic [TW-1:0] tcnt;

    logic accept, rd_ok, last_byte, word_done, final_word, tmo;
    logic [7:0] byte_nxt, tx_data_n;
    logic cmd_ready_n, tx_start_n, done_n, err_n;

    logic        cmd_ready_q, tx_start_q, rd_valid_q, rd_last_q, done_q, err_q;
    logic [7:0]  tx_data_q;
    logic [31:0] rd_data_q;

    assign accept     = bus.cmd_valid && cmd_ready_q;
    assign rd_ok      = (bus.cmd_addr[1:0] == 2'b00) && (bus.cmd_end_addr[1:0] == 2'b00) &&
                        (bus.cmd_end_addr > bus.cmd_addr);
    assign span       = 14'((bus.cmd_end_addr - bus.cmd_addr) >> 2);
    assign idx_inc    = idx + 3'd1;
    assign last_byte  = is_wr ? (idx == 3'd7) : (idx == 3'd4);
    assign word_done  = (state == RECV) && bus.rx_valid && (bcnt == 2'd3);
    assign final_word = word_done && (wcnt == 15'd1);
    assign tmo        = (state == RECV) && !bus.rx_valid && (tcnt == TMO_LAST);

    // Frame byte that follows the one currently in flight
    always_comb begin
        byte_nxt = 8'h00;
        if (is_wr) begin
            case (idx_inc)
                3'd1: byte_nxt = addr_q[7:0];
                3'd2: byte_nxt = addr_q[15:8];
                3'd3: byte_nxt = {4'b0000, wstrb_q};
                3'd4: byte_nxt = wdata_q[7:0];
                3'd5: byte_nxt = wdata_q[15:8];
                3'd6: byte_nxt = wdata_q[23:16];
                3'd7: byte_nxt = wdata_q[31:24];
                default: byte_nxt = 8'h0F;
            endcase
        end else begin
            case (idx_inc)
                3'd1: byte_nxt = addr_q[7:0];
                3'd2: byte_nxt = addr_q[15:8];
                3'd3: byte_nxt = end_q[7:0];
                3'd4: byte_nxt = end_q[15:8];
                default: byte_nxt = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (bus.cmd_write || rd_ok) ? SEND : REJECT;
            SEND:    state_nxt = WAIT_TX;
            WAIT_TX: if (bus.tx_done)
                         state_nxt = !last_byte ? SEND : (is_wr ? IDLE : RECV);
            RECV:    if (final_word || tmo) state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs are registered; these are their next-cycle values
    always_comb begin
        cmd_ready_n = (state_nxt == IDLE);
        tx_start_n  = (state_nxt == SEND);
        tx_data_n   = tx_data_q;
        if (state_nxt == SEND)
            tx_data_n = (state == IDLE) ? (bus.cmd_write ? 8'h0F : 8'hFF) : byte_nxt;
        done_n = ((state == WAIT_TX) && bus.tx_done && last_byte && is_wr) || final_word;
        err_n  = ((state == IDLE) && (state_nxt == REJECT)) || tmo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            is_wr       <= 1'b0;
            addr_q      <= 16'h0;
            end_q       <= 16'h0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            idx         <= 3'd0;
            bcnt        <= 2'd0;
            wcnt        <= 15'd0;
            shreg       <= 24'h0;
            tcnt        <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_n;
            tx_start_q  <= tx_start_n;
            tx_data_q   <= tx_data_n;
            rd_valid_q  <= word_done;
            rd_last_q   <= final_word;
            done_q      <= done_n;
            err_q       <= err_n;

            if (accept) begin
                is_wr   <= bus.cmd_write;
                addr_q  <= bus.cmd_addr;
                end_q   <= bus.cmd_end_addr;
                wstrb_q <= bus.cmd_wstrb;
                wdata_q <= bus.cmd_wdata;
                idx     <= 3'd0;
                wcnt    <= {1'b0, span};
            end else if ((state == WAIT_TX) && bus.tx_done && !last_byte) begin
                idx <= idx_inc;
            end

            // Outside RECV the byte lane and idle counter sit cleared, so a partial word never survives
            if (state != RECV) begin
                bcnt <= 2'd0;
                tcnt <= '0;
            end else if (bus.rx_valid) begin
                shreg <= {bus.rx_data, shreg[23:8]};
                bcnt  <= bcnt + 2'd1;
                tcnt  <= '0;
                if (bcnt == 2'd3) begin
                    rd_data_q <= {bus.rx_data, shreg};
                    wcnt      <= wcnt - 15'd1;
                end
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
